// File: rtl/uart_pkg.sv
// Shared UART constants for the echo design.
// Contents: data width, default bit period, 2-bit FSM state encodings
// (legacy constants plus an enum type built on them).
package uart_pkg;

  localparam int unsigned DATA_W               = 8;
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;  // 100 MHz / 115200 baud

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_START = ST_START,
    S_DATA  = ST_DATA,
    S_STOP  = ST_STOP
  } uart_state_e;

endpackage

// File: rtl/uart_rx.sv
// UART 8N1 receiver.
// Ports:
//   clk, resetn : system clock, asynchronous active-low reset
//   rx_i        : raw asynchronous receive line (idle high)
//   data_o      : last valid byte (held until the next one)
//   valid_o     : one-cycle pulse when data_o has a new byte
//   ferr_o      : one-cycle pulse on a framing error (stop bit low)
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              rx_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              ferr_o
);

  localparam int unsigned    CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]        sync_q;
  logic              prev_q;
  uart_state_e       state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              ferr_q, ferr_d;
  logic              rx;

  assign rx = sync_q[1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (prev_q && !rx) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx ? S_IDLE : S_DATA;  // high at mid-bit: glitch
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx, shift_q[DATA_W-1:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          if (rx) begin
            valid_d = 1'b1;
            data_d  = shift_q;
          end else begin
            ferr_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q  <= '1;
      prev_q  <= 1'b1;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rx_i};
      prev_q  <= rx;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign ferr_o  = ferr_q;

endmodule

// File: rtl/top.sv
// UART echo: received bytes are held in a one-entry buffer and re-sent.
// Ports:
//   clk, resetn : system clock, asynchronous active-low reset
//   ser_rx      : UART receive line (8N1, idle high)
//   ser_tx      : UART transmit line (8N1, idle high), flop-driven
//   led         : [2:0] low bits of last valid byte, [3] framing error
module top
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ser_rx,
  output logic       ser_tx,
  output logic [3:0] led
);

  localparam int unsigned   CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

  logic [DATA_W-1:0] rx_data;
  logic              rx_valid, rx_ferr;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk     (clk),
    .resetn  (resetn),
    .rx_i    (ser_rx),
    .data_o  (rx_data),
    .valid_o (rx_valid),
    .ferr_o  (rx_ferr)
  );

  logic [DATA_W-1:0] hold_q, hold_d;
  logic              full_q, full_d;
  uart_state_e       tx_state_q, tx_state_d;
  logic [CW-1:0]     tx_cnt_q, tx_cnt_d;
  logic [2:0]        tx_idx_q, tx_idx_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic              tx_q, tx_d;
  logic [3:0]        led_q, led_d;
  logic              tx_load;

  // Write-then-load: an idle TX takes a byte arriving this cycle directly,
  // so the holding register is bypassed rather than filled and drained.
  assign tx_load = (tx_state_q == S_IDLE) && (full_q || rx_valid);

  always_comb begin
    hold_d = hold_q;
    full_d = full_q;
    if (tx_load) begin
      full_d = 1'b0;
    end else if (rx_valid && !full_q) begin
      hold_d = rx_data;
      full_d = 1'b1;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 1'b1;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    unique case (tx_state_q)
      S_IDLE: begin
        tx_cnt_d = '0;
        tx_d     = 1'b1;
        if (tx_load) begin
          tx_state_d = S_START;
          tx_shift_d = full_q ? hold_q : rx_data;
          tx_d       = 1'b0;
        end
      end
      S_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_idx_d   = '0;
          tx_state_d = S_DATA;
          tx_d       = tx_shift_q[0];
        end
      end
      S_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_idx_q == 3'd7) begin
            tx_state_d = S_STOP;
            tx_d       = 1'b1;
          end else begin
            tx_idx_d   = tx_idx_q + 3'd1;
            tx_shift_d = tx_shift_q >> 1;
            tx_d       = tx_shift_q[1];
          end
        end
      end
      S_STOP: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = S_IDLE;
        end
      end
      default: tx_state_d = S_IDLE;
    endcase
  end

  always_comb begin
    led_d = led_q;
    if (rx_valid)     led_d = {1'b0, rx_data[2:0]};
    else if (rx_ferr) led_d[3] = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold_q     <= '0;
      full_q     <= 1'b0;
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
      led_q      <= '0;
    end else begin
      hold_q     <= hold_d;
      full_q     <= full_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
      led_q      <= led_d;
    end
  end

  assign ser_tx = tx_q;
  assign led    = led_q;

endmodule

// File: tb/tb_top.sv
// Self-checking bench for the UART echo top.
module tb_top;

  localparam int unsigned CPB = 16;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       ser_rx = 1'b1;
  logic       ser_tx;
  logic [3:0] led;
  logic       idle_rx = 1'b1;
  logic       idle_tx;
  logic [3:0] idle_led;

  always #5 clk = ~clk;

  top #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .resetn(resetn), .ser_rx(ser_rx), .ser_tx(ser_tx), .led(led)
  );

  top #(.CLKS_PER_BIT(868)) dut_idle (
    .clk(clk), .resetn(resetn), .ser_rx(idle_rx), .ser_tx(idle_tx), .led(idle_led)
  );

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
  endtask

  // Model: queue of bytes that must be echoed, and the LED value implied
  // by the bytes sent so far.
  logic [7:0]  exp_q[$];
  logic [3:0]  exp_led = 4'b0000;
  bit          chk_led = 1'b0;
  bit          started = 1'b0;

  // Frame monitor state
  bit          mon_in_frame = 1'b0;
  int unsigned mon_cyc = 0;
  logic [7:0]  mon_exp = '0;
  logic [7:0]  mon_shift = '0;
  logic [7:0]  last_byte = '0;
  int unsigned frames_started = 0;

  always @(negedge clk) begin
    int unsigned bitpos;
    logic        expbit;
    if (started) begin
      chk("idle868_led", {28'd0, idle_led}, 32'd0);
      chk("idle868_tx", {31'd0, idle_tx}, 32'd1);
    end
    if (!resetn) begin
      mon_in_frame = 1'b0;
      if (started) begin
        chk("reset_tx", {31'd0, ser_tx}, 32'd1);
        chk("reset_led", {28'd0, led}, 32'd0);
      end
    end else begin
      if (chk_led) chk("led", {28'd0, led}, {28'd0, exp_led});
      if (!mon_in_frame && ser_tx == 1'b0 && exp_q.size() != 0) begin
        mon_exp      = exp_q.pop_front();
        mon_in_frame = 1'b1;
        mon_cyc      = 0;
        frames_started++;
      end
      if (mon_in_frame) begin
        bitpos = mon_cyc / CPB;
        if (bitpos == 0)      expbit = 1'b0;
        else if (bitpos == 9) expbit = 1'b1;
        else                  expbit = mon_exp[bitpos-1];
        chk("tx_bit", {31'd0, ser_tx}, {31'd0, expbit});
        if (bitpos >= 1 && bitpos <= 8 && (mon_cyc % CPB) == CPB/2)
          mon_shift = {ser_tx, mon_shift[7:1]};
        mon_cyc++;
        if (mon_cyc == 10*CPB) begin
          mon_in_frame = 1'b0;
          last_byte    = mon_shift;
        end
      end else begin
        chk("tx_idle", {31'd0, ser_tx}, 32'd1);
      end
    end
  end

  task automatic drive_bit(input logic v);
    ser_rx = v;
    repeat (CPB) @(posedge clk);
  endtask

  task automatic send(input logic [7:0] b, input logic stop_bit);
    chk_led = 1'b0;
    if (stop_bit) exp_q.push_back(b);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_bit);
    ser_rx = 1'b1;
    repeat (8) @(posedge clk);
    if (stop_bit) exp_led = {1'b0, b[2:0]};
    else          exp_led[3] = 1'b1;
    chk_led = 1'b1;
  endtask

  task automatic wait_tx_done(input string name, input int unsigned budget);
    bit done = 1'b0;
    for (int unsigned i = 0; i < budget; i++) begin
      @(posedge clk);
      if (exp_q.size() == 0 && !mon_in_frame) begin
        done = 1'b1;
        break;
      end
    end
    chk(name, {31'd0, done}, 32'd1);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hit;
    #1 resetn = 1'b0;
    started = 1'b1;
    #100 resetn = 1'b1;
    chk_led = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    chk("post_reset_led", {28'd0, led}, 32'd0);
    chk("post_reset_tx", {31'd0, ser_tx}, 32'd1);

    // single echo
    send(8'hA5, 1'b1);
    wait_tx_done("echo_A5_done", 400);
    chk("echo_A5_byte", {24'd0, last_byte}, 32'hA5);
    chk("led_A5", {28'd0, led}, 32'b0101);

    // framing error, then recovery
    send(8'h3C, 1'b0);
    repeat (200) @(posedge clk);
    chk("ferr_led3", {31'd0, led[3]}, 32'd1);
    chk("ferr_no_frame", frames_started, 32'd1);
    send(8'h01, 1'b1);
    wait_tx_done("echo_01_done", 400);
    chk("echo_01_byte", {24'd0, last_byte}, 32'h01);
    chk("led_01", {28'd0, led}, 32'b0001);

    // glitch rejection
    ser_rx = 1'b0;
    repeat (4) @(posedge clk);
    ser_rx = 1'b1;
    repeat (200) @(posedge clk);
    chk("glitch_no_frame", frames_started, 32'd2);
    chk("glitch_led", {28'd0, led}, 32'b0001);

    // back-to-back bytes
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    send(8'h33, 1'b1);
    wait_tx_done("b2b_done", 1000);
    chk("b2b_frames", frames_started, 32'd5);
    chk("b2b_last", {24'd0, last_byte}, 32'h33);
    chk("b2b_led", {28'd0, led}, 32'b0011);

    // reset during TX data bit 3
    send(8'hC3, 1'b1);
    hit = 1'b0;
    for (int unsigned i = 0; i < 400; i++) begin
      @(posedge clk);
      if (mon_in_frame && mon_cyc >= 4*CPB + CPB/2) begin
        hit = 1'b1;
        break;
      end
    end
    chk("reach_tx_bit3", {31'd0, hit}, 32'd1);
    exp_q.delete();
    exp_led = 4'b0000;
    resetn = 1'b0;
    #1;
    chk("midtx_reset_tx", {31'd0, ser_tx}, 32'd1);
    chk("midtx_reset_led", {28'd0, led}, 32'd0);
    repeat (5) @(posedge clk);
    resetn = 1'b1;
    repeat (400) @(posedge clk);
    chk("midtx_frames", frames_started, 32'd6);
    chk("midtx_tx_idle", {31'd0, ser_tx}, 32'd1);

    // recovery after reset
    send(8'h5A, 1'b1);
    wait_tx_done("echo_5A_done", 400);
    chk("echo_5A_byte", {24'd0, last_byte}, 32'h5A);
    chk("led_5A", {28'd0, led}, 32'b0010);
    chk("total_frames", frames_started, 32'd7);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
